alu_exec_unit: RTL

Parametrised execute-stage ALU with its own operation decode. It takes the pipeline's 2-bit ALUOp, funct and shamt fields and computes the EX-stage result combinationally for single-cycle operations. Multiply and divide run on an iterative multi-cycle engine with HI/LO registers, and the unit raises a stall to the hazard unit while that engine is busy. It sits in EX between the ID/EX and EX/MEM registers.

---
 rtl/alu_exec_if.sv | 30 +++
 rtl/alu_exec_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// EX-stage ALU bus: decoded instruction fields and operands in, result/status and HI/LO out.
// The master side (ID/EX register) drives operands; the slave side is the execute unit.
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic [1:0]       ALUOp;
  logic [5:0]       funct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             stall;
  logic             md_done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, ALUOp, funct, shamt, a, b,
    input  result, zero, overflow, stall, md_done, hi, lo
  );

  modport slave (
    input  in_valid, ALUOp, funct, shamt, a, b,
    output result, zero, overflow, stall, md_done, hi, lo
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: combinational single-cycle ops plus an iterative
// shift-add / restoring-divide engine that owns HI/LO and stalls the pipe.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       reset,
  alu_exec_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t        state_reg;
  logic [SHW-1:0]   count_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic             is_div_reg;
  logic             a_neg_reg;
  logic             b_neg_reg;
  logic             b_zero_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             md_done_reg;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic             is_rtype;
  logic             md_req;
  logic             stall;
  logic             mthi_we;
  logic             mtlo_we;
  logic             op_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (bus.ALUOp)
      2'b00: alu_result = sum;
      2'b01: alu_result = diff;
      2'b11: alu_result = bus.a & bus.b;
      default: begin
        case (bus.funct)
          6'b100000, 6'b100001: alu_result = sum;
          6'b100010, 6'b100011: alu_result = diff;
          6'b100100: alu_result = bus.a & bus.b;
          6'b100101: alu_result = bus.a | bus.b;
          6'b100110: alu_result = bus.a ^ bus.b;
          6'b100111: alu_result = ~(bus.a | bus.b);
          6'b101010: alu_result = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
          6'b101011: alu_result = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
          6'b000000: alu_result = bus.b << bus.shamt;
          6'b000010: alu_result = bus.b >> bus.shamt;
          6'b000011: alu_result = $signed(bus.b) >>> bus.shamt;
          6'b000100: alu_result = bus.b << bus.a[SHW-1:0];
          6'b000110: alu_result = bus.b >> bus.a[SHW-1:0];
          6'b000111: alu_result = $signed(bus.b) >>> bus.a[SHW-1:0];
          6'b010000: alu_result = hi_reg;
          6'b010010: alu_result = lo_reg;
          default:   alu_result = '0;
        endcase
        // Only the trapping add/sub forms report overflow; the unsigned forms never do.
        if (bus.funct == 6'b100000)
          alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        else if (bus.funct == 6'b100010)
          alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
    endcase
  end

  assign is_rtype = bus.in_valid && (bus.ALUOp == 2'b10);
  assign md_req   = is_rtype && (bus.funct[5:2] == 4'b0110);
  assign stall    = !reset && (((state_reg == IDLE) && md_req) || (state_reg == BUSY));
  assign mthi_we  = is_rtype && !stall && (bus.funct == 6'b010001);
  assign mtlo_we  = is_rtype && !stall && (bus.funct == 6'b010011);

  // funct[0]==0 selects the signed forms of mult and div.
  assign op_signed = !bus.funct[0];
  assign mag_a     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One iteration of each algorithm, computed from the current accumulator.
  logic [WIDTH:0]     mul_add;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_mag;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  always_comb begin
    mul_add   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, divisor_reg} : {(WIDTH+1){1'b0}});
    div_trial = {acc_hi_reg, acc_lo_reg[WIDTH-1]} - {1'b0, divisor_reg};
    if (is_div_reg) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi_reg[WIDTH-2:0], acc_lo_reg[WIDTH-1]};
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_add[WIDTH:1];
      step_lo = {mul_add[0], acc_lo_reg[WIDTH-1:1]};
    end

    prod_mag = {step_hi, step_lo};
    if (!is_div_reg) begin
      if (a_neg_reg ^ b_neg_reg)
        prod_mag = -prod_mag;
      fin_hi = prod_mag[2*WIDTH-1:WIDTH];
      fin_lo = prod_mag[WIDTH-1:0];
    end else if (b_zero_reg) begin
      fin_hi = dividend_reg;
      fin_lo = '1;
    end else begin
      // Quotient sign from both operands, remainder sign follows the dividend.
      fin_lo = (a_neg_reg ^ b_neg_reg) ? -step_lo : step_lo;
      fin_hi = a_neg_reg ? -step_hi : step_hi;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      divisor_reg  <= '0;
      dividend_reg <= '0;
      is_div_reg   <= 1'b0;
      a_neg_reg    <= 1'b0;
      b_neg_reg    <= 1'b0;
      b_zero_reg   <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      md_done_reg  <= 1'b0;
    end else begin
      md_done_reg <= 1'b0;
      if (mthi_we) hi_reg <= bus.a;
      if (mtlo_we) lo_reg <= bus.a;
      case (state_reg)
        IDLE: begin
          if (md_req) begin
            acc_hi_reg   <= '0;
            acc_lo_reg   <= mag_a;
            divisor_reg  <= mag_b;
            dividend_reg <= bus.a;
            is_div_reg   <= bus.funct[1];
            a_neg_reg    <= op_signed && bus.a[WIDTH-1];
            b_neg_reg    <= op_signed && bus.b[WIDTH-1];
            b_zero_reg   <= (bus.b == '0);
            count_reg    <= SHW'(WIDTH - 1);
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          acc_hi_reg <= step_hi;
          acc_lo_reg <= step_lo;
          if (count_reg == '0) begin
            hi_reg      <= fin_hi;
            lo_reg      <= fin_lo;
            md_done_reg <= 1'b1;
            state_reg   <= DONE;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        // The held mult/div instruction retires here without restarting the engine.
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.result   = alu_result;
  assign bus.zero     = (alu_result == '0);
  assign bus.overflow = alu_ovf;
  assign bus.stall    = stall;
  assign bus.md_done  = md_done_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

endmodule
